// File: rtl/delay_measure_if.sv
// Tap bundle for the reference and delayed AXI-stream qualifiers.
// The monitor only observes these signals; it never drives any of them.
interface delay_measure_if;
    logic ref_tvalid;
    logic ref_tready;
    logic ref_tlast;
    logic dut_tvalid;
    logic dut_tready;
    logic dut_tlast;

    // Whoever owns the streams (or the bench) drives every tap
    modport master (
        output ref_tvalid, ref_tready, ref_tlast,
        output dut_tvalid, dut_tready, dut_tlast
    );

    // Passive monitor side: every tap is an input
    modport slave (
        input ref_tvalid, ref_tready, ref_tlast,
        input dut_tvalid, dut_tready, dut_tlast
    );
endinterface

// File: rtl/delay_measure.sv
// Passive monitor that counts reference beats between a reference
// end-of-packet and the next delayed-stream end-of-packet. It averages
// 2^AVG_LOG2 such measurements into a registered len output, and it
// reports timeouts and negative offsets as one-cycle pulses.
module delay_measure #(
    parameter int MAX_LEN_LOG2 = 10,
    parameter int AVG_LOG2     = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    delay_measure_if.slave          s_taps,
    output logic [MAX_LEN_LOG2-1:0] len,
    output logic                    len_valid,
    output logic                    overflow,
    output logic                    early
);
    localparam int CW = MAX_LEN_LOG2;
    localparam int AW = MAX_LEN_LOG2 + AVG_LOG2;
    // Keep the measurement counter one bit wide when no averaging is requested
    localparam int NW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] MAXC  = '1;
    localparam logic [NW-1:0] NLAST = NW'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REF_FIRST = 2'd1,
        S_DUT_FIRST = 2'd2
    } state_t;

    // Qualified tap events
    logic w_ref_beat;
    logic w_ref_eop;
    logic w_dut_eop;

    // Offset FSM
    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_commit;
    logic [CW-1:0]   w_meas;
    logic            w_ovf_nxt;
    logic            w_early_nxt;

    // Averaging datapath
    logic [AW-1:0]   r_acc;
    logic [AW-1:0]   w_acc_sum;
    logic [NW-1:0]   r_nmeas;
    logic            w_avg_done;

    // Registered outputs
    logic [CW-1:0]   r_len;
    logic            r_len_valid;
    logic            r_overflow;
    logic            r_early;

    assign w_ref_beat = s_taps.ref_tvalid & s_taps.ref_tready;
    assign w_ref_eop  = w_ref_beat & s_taps.ref_tlast;
    assign w_dut_eop  = s_taps.dut_tvalid & s_taps.dut_tready & s_taps.dut_tlast;

    // The accumulator is wide enough for 2^AVG_LOG2 full-scale samples
    assign w_acc_sum  = r_acc + AW'(w_meas);
    assign w_avg_done = (r_nmeas == NLAST);

    // Next state, offset count and event flags for the measurement FSM
    always_comb begin
        // NOTE: every output gets a default first, so no path can leave a latch behind.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        w_meas      = '0;
        w_ovf_nxt   = 1'b0;
        w_early_nxt = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_ref_eop && w_dut_eop) begin
                    w_commit = 1'b1;
                end else if (w_ref_eop) begin
                    w_state_nxt = S_REF_FIRST;
                    w_cnt_nxt   = '0;
                end else if (w_dut_eop) begin
                    w_state_nxt = S_DUT_FIRST;
                    w_cnt_nxt   = '0;
                end
            end

            S_REF_FIRST: begin
                if (w_dut_eop) begin
                    // The reference beat of the closing cycle still counts
                    w_commit    = 1'b1;
                    w_meas      = r_cnt + CW'(w_ref_beat);
                    w_state_nxt = S_IDLE;
                end else if (w_ref_eop) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == MAXC && w_ref_beat) begin
                    w_ovf_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(w_ref_beat);
                end
            end

            S_DUT_FIRST: begin
                if (w_ref_eop) begin
                    // A negative offset is reported and clamped to zero
                    w_early_nxt = 1'b1;
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_dut_eop) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == MAXC && w_ref_beat) begin
                    w_ovf_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(w_ref_beat);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and offset counter registers; clear behaves like reset
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (clear) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Accumulate committed measurements and publish the average
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc       <= '0;
            r_nmeas     <= '0;
            r_len       <= '0;
            r_len_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_early     <= 1'b0;
        end else if (clear) begin
            r_acc       <= '0;
            r_nmeas     <= '0;
            r_len       <= '0;
            r_len_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_early     <= 1'b0;
        end else begin
            r_len_valid <= 1'b0;
            r_overflow  <= w_ovf_nxt;
            r_early     <= w_early_nxt;
            if (w_commit) begin
                if (w_avg_done) begin
                    r_len       <= CW'(w_acc_sum >> AVG_LOG2);
                    r_len_valid <= 1'b1;
                    r_acc       <= '0;
                    r_nmeas     <= '0;
                end else begin
                    r_acc   <= w_acc_sum;
                    r_nmeas <= r_nmeas + NW'(1);
                end
            end
        end
    end

    assign len       = r_len;
    assign len_valid = r_len_valid;
    assign overflow  = r_overflow;
    assign early     = r_early;
endmodule

// File: tb/tb_delay_measure.sv
// Bench for delay_measure. Three instances share one tap bundle:
//   k=0: MAX_LEN_LOG2=10, AVG_LOG2=0
//   k=1: MAX_LEN_LOG2=10, AVG_LOG2=2
//   k=2: MAX_LEN_LOG2=4,  AVG_LOG2=0
// A reference model tracks the offset as the difference in running
// reference-beat totals and averages with plain arithmetic.
module tb_delay_measure;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic clear;
    delay_measure_if taps();

    wire [9:0] len_a0;
    wire [9:0] len_a2;
    wire [3:0] len_m4;
    wire [2:0] lv;
    wire [2:0] ov;
    wire [2:0] ea;

    delay_measure #(.MAX_LEN_LOG2(10), .AVG_LOG2(0)) u_a0 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .s_taps(taps.slave),
        .len(len_a0), .len_valid(lv[0]), .overflow(ov[0]), .early(ea[0])
    );
    delay_measure #(.MAX_LEN_LOG2(10), .AVG_LOG2(2)) u_a2 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .s_taps(taps.slave),
        .len(len_a2), .len_valid(lv[1]), .overflow(ov[1]), .early(ea[1])
    );
    delay_measure #(.MAX_LEN_LOG2(4), .AVG_LOG2(0)) u_m4 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .s_taps(taps.slave),
        .len(len_m4), .len_valid(lv[2]), .overflow(ov[2]), .early(ea[2])
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    int k_maxc[3] = '{1023, 1023, 15};
    int k_navg[3] = '{1, 4, 1};
    int total;
    int m_pend[3];     // 0 none, 1 reference eop pending, 2 dut eop pending
    int m_mark[3];     // running beat total at the pending eop
    int m_sum[3];
    int m_cnt[3];
    int e_len[3];
    bit e_lv[3];
    bit e_ov[3];
    bit e_ea[3];
    int p_lv[3];
    int p_ov[3];
    int p_ea[3];

    function automatic int obs_len(int k);
        if (k == 0) return int'(len_a0);
        if (k == 1) return int'(len_a2);
        return int'(len_m4);
    endfunction

    task automatic model_reset();
        total = 0;
        for (int k = 0; k < 3; k++) begin
            m_pend[k] = 0; m_mark[k] = 0; m_sum[k] = 0; m_cnt[k] = 0;
            e_len[k] = 0; e_lv[k] = 0; e_ov[k] = 0; e_ea[k] = 0;
            p_lv[k] = 0; p_ov[k] = 0; p_ea[k] = 0;
        end
    endtask

    task automatic model_step(input bit rb, input bit re, input bit de, input bit clr);
        int elapsed;
        int m;
        bit do_commit;
        if (clr) begin
            model_reset();
            return;
        end
        total += int'(rb);
        for (int k = 0; k < 3; k++) begin
            e_lv[k] = 0; e_ov[k] = 0; e_ea[k] = 0;
            do_commit = 0;
            m = 0;
            elapsed = total - m_mark[k];
            if (m_pend[k] == 0) begin
                if (re && de) do_commit = 1;
                else if (re) begin m_pend[k] = 1; m_mark[k] = total; end
                else if (de) begin m_pend[k] = 2; m_mark[k] = total; end
            end else if (m_pend[k] == 1) begin
                if (de) begin do_commit = 1; m = elapsed % (k_maxc[k] + 1); m_pend[k] = 0; end
                else if (re) m_mark[k] = total;
                else if (elapsed > k_maxc[k]) begin e_ov[k] = 1; m_pend[k] = 0; end
            end else begin
                if (re) begin e_ea[k] = 1; do_commit = 1; m_pend[k] = 0; end
                else if (de) m_mark[k] = total;
                else if (elapsed > k_maxc[k]) begin e_ov[k] = 1; m_pend[k] = 0; end
            end
            if (do_commit) begin
                m_sum[k] += m;
                m_cnt[k] += 1;
                if (m_cnt[k] == k_navg[k]) begin
                    e_len[k] = m_sum[k] / k_navg[k];
                    e_lv[k]  = 1;
                    m_sum[k] = 0;
                    m_cnt[k] = 0;
                end
            end
        end
    endtask

    // Drive one cycle of taps, let the edge happen, then update the model
    task automatic step(input bit rv, input bit rr, input bit rl,
                        input bit dv, input bit dr, input bit dl, input bit clr);
        taps.ref_tvalid = rv; taps.ref_tready = rr; taps.ref_tlast = rl;
        taps.dut_tvalid = dv; taps.dut_tready = dr; taps.dut_tlast = dl;
        clear = clr;
        @(posedge clk);
        #1;
        model_step(rv & rr, rv & rr & rl, dv & dr & dl, clr);
        for (int k = 0; k < 3; k++) begin
            p_lv[k] += int'(lv[k] === 1'b1);
            p_ov[k] += int'(ov[k] === 1'b1);
            p_ea[k] += int'(ea[k] === 1'b1);
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic beat(input bit rl, input bit de);
        step(1, 1, rl, de, 1, de, 0);
    endtask

    task automatic do_clear();
        step(0, 0, 0, 0, 0, 0, 1);
    endtask

    // Reference eop, then m reference beats with the dut eop on the last one
    task automatic measure(input int m);
        if (m == 0) begin
            beat(1, 1);
        end else begin
            beat(1, 0);
            repeat (m - 1) beat(0, 0);
            beat(0, 1);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        clear   = 1'b0;
        taps.ref_tvalid = 0; taps.ref_tready = 0; taps.ref_tlast = 0;
        taps.dut_tvalid = 0; taps.dut_tready = 0; taps.dut_tlast = 0;
        #1 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({len_a0, len_a2, len_m4} !== 24'd0) begin
            tests_failed++;
            $display("FAIL reset_len: got %h/%h/%h expected 0", len_a0, len_a2, len_m4);
        end
        tests_run++;
        if ({lv, ov, ea} !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset_pulses: got %b expected 0", {lv, ov, ea});
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_avg0();
        do_clear();
        beat(1, 0);
        repeat (4) beat(0, 0);
        tests_run++;
        if (p_lv[0] !== 0) begin
            tests_failed++;
            $display("FAIL single_early_pulse: got %0d pulses expected 0", p_lv[0]);
        end
        beat(0, 1);
        tests_run++;
        if (len_a0 !== 10'd5 || lv[0] !== 1'b1 || len_m4 !== 4'd5) begin
            tests_failed++;
            $display("FAIL single_len5: got len %0d/%0d valid %b expected 5/5 valid 1", len_a0, len_m4, lv[0]);
        end
        idle();
        tests_run++;
        if (lv[0] !== 1'b0 || p_lv[0] !== 1 || len_a0 !== 10'd5) begin
            tests_failed++;
            $display("FAIL single_hold: got valid %b pulses %0d len %0d expected 0 1 5", lv[0], p_lv[0], len_a0);
        end
    endtask

    task automatic test_average();
        do_clear();
        measure(3); measure(4); measure(4);
        tests_run++;
        if (p_lv[1] !== 0) begin
            tests_failed++;
            $display("FAIL avg_partial: got %0d pulses expected 0", p_lv[1]);
        end
        measure(6);
        tests_run++;
        if (len_a2 !== 10'd4 || lv[1] !== 1'b1 || p_lv[1] !== 1) begin
            tests_failed++;
            $display("FAIL avg_len4: got len %0d valid %b pulses %0d expected 4 1 1", len_a2, lv[1], p_lv[1]);
        end
    endtask

    task automatic test_same_cycle();
        do_clear();
        repeat (4) measure(5);
        repeat (3) measure(0);
        tests_run++;
        if (len_a2 !== 10'd5 || p_lv[1] !== 1) begin
            tests_failed++;
            $display("FAIL same_partial: got len %0d pulses %0d expected 5 1", len_a2, p_lv[1]);
        end
        measure(0);
        tests_run++;
        if (len_a2 !== 10'd0 || lv[1] !== 1'b1 || p_lv[1] !== 2) begin
            tests_failed++;
            $display("FAIL same_len0: got len %0d valid %b pulses %0d expected 0 1 2", len_a2, lv[1], p_lv[1]);
        end
    endtask

    task automatic test_early();
        do_clear();
        repeat (4) measure(8);
        tests_run++;
        if (len_a2 !== 10'd8) begin
            tests_failed++;
            $display("FAIL early_prime: got len %0d expected 8", len_a2);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 1, 1, 0);
            beat(0, 0);
            beat(0, 0);
            beat(1, 0);
            tests_run++;
            if (ea[1] !== 1'b1 || ea[0] !== 1'b1) begin
                tests_failed++;
                $display("FAIL early_pulse_%0d: got %b/%b expected 1/1", i, ea[1], ea[0]);
            end
        end
        idle();
        tests_run++;
        if (len_a2 !== 10'd0 || p_ea[1] !== 4 || p_lv[1] !== 2 || ea[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL early_len0: got len %0d early %0d pulses %0d expected 0 4 2", len_a2, p_ea[1], p_lv[1]);
        end
    endtask

    task automatic test_overflow();
        do_clear();
        beat(1, 0);
        repeat (15) beat(0, 0);
        tests_run++;
        if (ov[2] !== 1'b0 || p_ov[2] !== 0) begin
            tests_failed++;
            $display("FAIL ovf_too_soon: got %b/%0d expected 0/0", ov[2], p_ov[2]);
        end
        beat(0, 0);
        tests_run++;
        if (ov[2] !== 1'b1 || ov[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_pulse: got m4 %b a0 %b expected 1 0", ov[2], ov[0]);
        end
        idle();
        tests_run++;
        if (ov[2] !== 1'b0 || p_ov[2] !== 1 || p_lv[2] !== 0) begin
            tests_failed++;
            $display("FAIL ovf_after: got ovf %b count %0d lv %0d expected 0 1 0", ov[2], p_ov[2], p_lv[2]);
        end
        measure(7);
        tests_run++;
        if (len_m4 !== 4'd7 || lv[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_recover: got len %0d valid %b expected 7 1", len_m4, lv[2]);
        end
    endtask

    task automatic test_restart();
        do_clear();
        beat(1, 0);
        repeat (3) beat(0, 0);
        beat(1, 0);
        beat(0, 0);
        beat(0, 1);
        tests_run++;
        if (len_a0 !== 10'd2 || lv[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_len2: got len %0d valid %b expected 2 1", len_a0, lv[0]);
        end
    endtask

    task automatic test_qualify();
        do_clear();
        beat(1, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 1, 1, 0);
        beat(0, 1);
        tests_run++;
        if (len_a0 !== 10'd1 || p_lv[0] !== 1) begin
            tests_failed++;
            $display("FAIL qualify_len1: got len %0d pulses %0d expected 1 1", len_a0, p_lv[0]);
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        measure(3);
        tests_run++;
        if (len_a0 !== 10'd3 || lv[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first: got len %0d valid %b expected 3 1", len_a0, lv[0]);
        end
        measure(4);
        tests_run++;
        if (len_a0 !== 10'd4 || p_lv[0] !== 2) begin
            tests_failed++;
            $display("FAIL b2b_second: got len %0d pulses %0d expected 4 2", len_a0, p_lv[0]);
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        measure(9);
        tests_run++;
        if (len_a0 !== 10'd9) begin
            tests_failed++;
            $display("FAIL areset_prime: got len %0d expected 9", len_a0);
        end
        beat(1, 0);
        beat(0, 0);
        idle();
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (len_a0 !== 10'd0 || {lv, ov, ea} !== 9'd0) begin
            tests_failed++;
            $display("FAIL areset_immediate: got len %0d pulses %b expected 0 0", len_a0, {lv, ov, ea});
        end
        @(negedge clk) reset_n = 1'b1;
        model_reset();
        beat(0, 1);
        tests_run++;
        if (lv[0] !== 1'b0 || len_a0 !== 10'd0) begin
            tests_failed++;
            $display("FAIL areset_discard: got valid %b len %0d expected 0 0", lv[0], len_a0);
        end
    endtask

    task automatic test_clear();
        do_clear();
        measure(2);
        measure(2);
        do_clear();
        repeat (3) measure(8);
        tests_run++;
        if (p_lv[1] !== 0) begin
            tests_failed++;
            $display("FAIL clear_partial: got %0d pulses expected 0", p_lv[1]);
        end
        measure(8);
        tests_run++;
        if (len_a2 !== 10'd8 || lv[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_len8: got len %0d valid %b expected 8 1", len_a2, lv[1]);
        end
    endtask

    task automatic test_random();
        bit rv, rr, rl, dv, dr, dl, clr;
        do_clear();
        for (int c = 0; c < 4000; c++) begin
            rv  = ($urandom_range(0, 9) < 7);
            rr  = ($urandom_range(0, 9) < 7);
            rl  = ($urandom_range(0, 9) < 2);
            dv  = ($urandom_range(0, 9) < 6);
            dr  = ($urandom_range(0, 9) < 7);
            dl  = ($urandom_range(0, 9) < 2);
            clr = ($urandom_range(0, 299) == 0);
            step(rv, rr, rl, dv, dr, dl, clr);
            for (int k = 0; k < 3; k++) begin
                tests_run++;
                if (obs_len(k) !== e_len[k] || lv[k] !== e_lv[k] ||
                    ov[k] !== e_ov[k] || ea[k] !== e_ea[k]) begin
                    tests_failed++;
                    $display("FAIL random_c%0d_k%0d: got len %0d lv %b ov %b ea %b expected len %0d lv %b ov %b ea %b",
                             c, k, obs_len(k), lv[k], ov[k], ea[k], e_len[k], e_lv[k], e_ov[k], e_ea[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_avg0();
        test_average();
        test_same_cycle();
        test_early();
        test_overflow();
        test_restart();
        test_qualify();
        test_back_to_back();
        test_async_reset();
        test_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/delay_measure.md
# delay_measure

Passive AXI-stream monitor that measures the sample offset between a reference stream and a delayed (DUT) stream, and produces the `len` target used by the per-packet delay adjuster. It taps beat and `tlast` qualifiers only. It never drives `tready` and never alters either stream. Each measurement is the count of reference beats between a reference end-of-packet and the next DUT end-of-packet. The block averages 2^AVG_LOG2 measurements and presents the result on a registered output.

## Interface
Parameters:
- MAX_LEN_LOG2, 10: width of `len` and of the offset counter; also sets the timeout.
- AVG_LOG2, 2: log2 of the number of measurements averaged per output.

Ports:
- clk  in  1  clock; all logic in this single domain.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear; same effect as reset; overrides all other inputs.
- ref_tvalid, ref_tready, ref_tlast  in  1 each  reference stream tap.
- dut_tvalid, dut_tready, dut_tlast  in  1 each  delayed stream tap.
- len  out  MAX_LEN_LOG2  averaged offset in samples; held between updates.
- len_valid  out  1  one-cycle pulse on each `len` update.
- overflow  out  1  one-cycle pulse when a measurement times out.
- early  out  1  one-cycle pulse when a DUT end-of-packet precedes the reference one.

## Operation
Definitions:
- ref_beat = ref_tvalid & ref_tready; ref_eop = ref_beat & ref_tlast. dut_eop is defined likewise on the dut_* signals.
- cnt: MAX_LEN_LOG2 bits, unsigned. MAXC = 2^MAX_LEN_LOG2 - 1.

State machine (reset/clear -> IDLE, cnt = 0):
- IDLE:
  - ref_eop & dut_eop in the same cycle -> commit measurement 0, stay IDLE.
  - ref_eop alone -> REF_FIRST, cnt = 0.
  - dut_eop alone -> DUT_FIRST, cnt = 0.
- REF_FIRST (counting ref beats):
  - dut_eop -> commit cnt + ref_beat, go to IDLE. A ref_eop in the same cycle is ignored.
  - else ref_eop -> restart: cnt = 0, stay REF_FIRST. No commit, no pulse.
  - else cnt == MAXC and ref_beat -> overflow pulse, go to IDLE, no commit.
  - else cnt += ref_beat.
- DUT_FIRST:
  - ref_eop -> early pulse, commit measurement 0 (negative offsets clamp to 0), go to IDLE.
  - else dut_eop -> restart, cnt = 0.
  - else cnt == MAXC and ref_beat -> overflow pulse, go to IDLE, no commit.
  - else cnt += ref_beat.

Averaging:
- Each commit adds the measurement to acc (width MAX_LEN_LOG2 + AVG_LOG2; cannot overflow) and increments nmeas (AVG_LOG2 bits).
- When a commit makes nmeas reach 2^AVG_LOG2: len = (acc + m) >> AVG_LOG2, truncated; len_valid pulses; acc and nmeas return to 0.
- With AVG_LOG2 = 0, every commit updates `len` directly.
- Overflow and restart events leave acc and nmeas untouched.

## Timing
- Reset values: len = 0, len_valid = 0, overflow = 0, early = 0, state IDLE, cnt/acc/nmeas = 0.
- reset_n low forces all outputs to 0 immediately, regardless of clk. Deassertion is taken synchronously to clk by the surrounding reset logic.
- clear high at any edge: same state as reset at that edge; any partial measurement and partial average are discarded.
- Latency: the terminating event in cycle N gives `len`/len_valid (or overflow/early) in cycle N+1. All outputs are registered.
- Back-to-back: a commit in cycle N and a new ref_eop in cycle N+1 are both honoured; the block is in IDLE from cycle N+1.
- Input taps are sampled only when the corresponding tvalid & tready is high. tdata is not observed.

## Test plan
- AVG_LOG2=0: ref_eop, then 5 ref beats, dut_eop on the 5th -> len = 5 and a single len_valid pulse exactly one cycle after dut_eop.
- AVG_LOG2=2: measurements 3, 4, 4, 6 (sum 17) -> exactly one len_valid pulse, after the 4th measurement, with len = 4. No pulse after the first three.
- ref_eop and dut_eop in the same cycle from IDLE, four times (AVG_LOG2=2) -> len = 0. Repeat with dut_eop 2 beats before ref_eop -> early pulses each time, len = 0.
- MAX_LEN_LOG2=4: ref_eop, then 16 ref beats with no dut_eop -> overflow pulse on the cycle after the 16th beat, return to IDLE, no len_valid. A following valid measurement of 7 (AVG_LOG2=0) -> len = 7.
- REF_FIRST: second ref_eop after 3 beats, then dut_eop 2 beats later -> len = 2 (restart honoured).
- reset_n pulled low mid-count with len = 9 -> len = 0 with no clk edge. clear asserted after 2 of 4 averaged measurements, then 4 measurements of value 8 -> len = 8.
